// File: rtl/fp_round_pipe_pkg.sv
// fp_round_pipe_pkg: FP32 rounding types and the saturation helpers shared by the rounding pipe.
// Rev 1.0
`default_nettype none

package fp_round_pipe_pkg;

  localparam int unsigned EXP_BITS  = 8;
  localparam int unsigned MANT_BITS = 23;
  localparam logic [EXP_BITS-1:0] EXP_MAX = 8'hFF;
  localparam logic [30:0] INF_MAG = 31'h7F80_0000;
  localparam logic [30:0] MAX_MAG = 31'h7F7F_FFFF;
  localparam logic [30:0] MIN_MAG = 31'h0000_0001;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } roundmode_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef struct packed {
    logic                 sign;
    logic [EXP_BITS-1:0]  exponent;
    logic [MANT_BITS-1:0] mantissa;
  } fp_encoding_t;

  typedef struct packed {
    fp_encoding_t u_result;
    logic [1:0]   rs;
    logic         round_en;
    logic         invalid;
    logic [1:0]   exp_cout;
  } uround_res_t;

  // Directed modes saturate to max finite when rounding away from infinity.
  function automatic logic [31:0] overflow_result(input logic sign, input roundmode_e rm);
    logic [30:0] mag;
    mag = INF_MAG;
    case (rm)
      RM_RTZ:  mag = MAX_MAG;
      RM_RUP:  mag = sign ? MAX_MAG : INF_MAG;
      RM_RDN:  mag = sign ? INF_MAG : MAX_MAG;
      default: mag = INF_MAG;
    endcase
    return {sign, mag};
  endfunction

  function automatic logic [31:0] underflow_result(input logic sign, input roundmode_e rm);
    logic [30:0] mag;
    mag = 31'd0;
    if ((rm == RM_RUP && !sign) || (rm == RM_RDN && sign)) begin
      mag = MIN_MAG;
    end
    return {sign, mag};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_round_pipe_if.sv
// fp_round_pipe_if: input/output valid-ready channels of the FP32 rounding pipe.
// Rev 1.0
`default_nettype none

interface fp_round_pipe_if;
  import fp_round_pipe_pkg::*;

  logic        in_valid_i;
  logic        in_ready_o;
  uround_res_t urnd_i;
  logic [2:0]  rm_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;

  modport slave (
    input  in_valid_i,
    input  urnd_i,
    input  rm_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output result_o,
    output fflags_o
  );

  modport master (
    output in_valid_i,
    output urnd_i,
    output rm_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  result_o,
    input  fflags_o
  );

endinterface

`default_nettype wire

// File: rtl/fp_round_pipe_decide.sv
// fp_round_decide: per-mode round-increment decision from sign, lsb, round and sticky bits.
// Rev 1.0
`default_nettype none

module fp_round_decide
  import fp_round_pipe_pkg::*;
(
  input  wire logic       sign_i,
  input  wire logic       l_i,
  input  wire logic       r_i,
  input  wire logic       s_i,
  input  wire roundmode_e rm_i,
  output logic            inc_o
);

  always_comb begin
    inc_o = 1'b0;
    case (rm_i)
      RM_RTZ:  inc_o = 1'b0;
      RM_RDN:  inc_o = sign_i & (r_i | s_i);
      RM_RUP:  inc_o = ~sign_i & (r_i | s_i);
      RM_RMM:  inc_o = r_i;
      default: inc_o = r_i & (s_i | l_i);
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage FP32 rounding unit with valid/ready flow control and flush.
// Rev 1.0
`default_nettype none

module fp_round_pipe
  import fp_round_pipe_pkg::*;
(
  input  wire logic       clk_i,
  input  wire logic       rst_ni,
  input  wire logic       flush_i,
  fp_round_pipe_if.slave  bus
);

  logic        s1_valid_q, s1_valid_d;
  uround_res_t s1_urnd_q, s1_urnd_d;
  logic [2:0]  s1_rm_q, s1_rm_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_result_q, s2_result_d;
  fflags_t     s2_flags_q, s2_flags_d;

  logic        in_ready;
  logic        accept;
  logic        s2_load;

  roundmode_e  rm;
  logic        sign;
  logic [7:0]  expo;
  logic [22:0] mant;
  logic        rbit, sbit, lbit;
  logic        inc;
  logic [30:0] sum;
  logic [31:0] res;
  fflags_t     flags;

  // S1 may refill whenever it empties into S2 this cycle, so ready looks only at state.
  assign in_ready = ~s1_valid_q | ~s2_valid_q | bus.out_ready_i;
  assign accept   = bus.in_valid_i & in_ready;
  assign s2_load  = s1_valid_q & (~s2_valid_q | bus.out_ready_i);

  assign rm   = roundmode_e'(s1_rm_q);
  assign sign = s1_urnd_q.u_result.sign;
  assign expo = s1_urnd_q.u_result.exponent;
  assign mant = s1_urnd_q.u_result.mantissa;
  assign rbit = s1_urnd_q.rs[1];
  assign sbit = s1_urnd_q.rs[0];
  assign lbit = mant[0];

  fp_round_decide u_decide (
    .sign_i (sign),
    .l_i    (lbit),
    .r_i    (rbit),
    .s_i    (sbit),
    .rm_i   (rm),
    .inc_o  (inc)
  );

  assign sum = {expo, mant} + {30'd0, inc};

  always_comb begin
    res   = 32'd0;
    flags = '0;
    if (!s1_urnd_q.round_en) begin
      res      = s1_urnd_q.u_result;
      flags.nv = s1_urnd_q.invalid;
    end else if (s1_urnd_q.exp_cout[1]) begin
      res      = underflow_result(sign, rm);
      flags.uf = 1'b1;
      flags.nx = 1'b1;
    end else if (s1_urnd_q.exp_cout[0] || expo == EXP_MAX || sum[30:23] == EXP_MAX) begin
      // A mantissa carry into an all-ones exponent lands here as well.
      res      = overflow_result(sign, rm);
      flags.of = 1'b1;
      flags.nx = 1'b1;
    end else begin
      res      = {sign, sum};
      flags.nx = rbit | sbit;
      flags.uf = (rbit | sbit) & (expo == 8'd0);
      flags.nv = s1_urnd_q.invalid;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_urnd_d   = s1_urnd_q;
    s1_rm_d     = s1_rm_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;

    if (accept) begin
      s1_urnd_d = bus.urnd_i;
      s1_rm_d   = bus.rm_i;
    end
    if (s2_load) begin
      s2_result_d = res;
      s2_flags_d  = flags;
    end

    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
      end else if (s2_load) begin
        s1_valid_d = 1'b0;
      end
      if (s2_load) begin
        s2_valid_d = 1'b1;
      end else if (bus.out_ready_i) begin
        s2_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_urnd_q   <= '0;
      s1_rm_q     <= 3'd0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= 32'd0;
      s2_flags_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_urnd_q   <= s1_urnd_d;
      s1_rm_q     <= s1_rm_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_flags_q  <= s2_flags_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = s2_valid_q;
  assign bus.result_o    = s2_result_q;
  assign bus.fflags_o    = s2_flags_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe: directed self-checking bench for the FP32 rounding pipe.
// Rev 1.0
`default_nettype none

module tb_fp_round_pipe;
  import fp_round_pipe_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  int   errors;
  int   checks;

  fp_round_pipe_if bus ();

  fp_round_pipe dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [31:0] ures, input logic [1:0] rs, input logic ren,
                       input logic inv, input logic [1:0] cout, input logic [2:0] rm);
    bus.urnd_i.u_result = ures;
    bus.urnd_i.rs       = rs;
    bus.urnd_i.round_en = ren;
    bus.urnd_i.invalid  = inv;
    bus.urnd_i.exp_cout = cout;
    bus.rm_i            = rm;
  endtask

  // Called at posedge+1; one accept, then checks latency and the result.
  task automatic run_one(input string tag, input logic [31:0] ures, input logic [1:0] rs,
                         input logic ren, input logic inv, input logic [1:0] cout,
                         input logic [2:0] rm, input logic [31:0] er, input logic [4:0] ef);
    drive(ures, rs, ren, inv, cout, rm);
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk({tag, ".in_ready"}, {31'd0, bus.in_ready_o}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    chk({tag, ".lat1"}, {31'd0, bus.out_valid_o}, 32'd0);
    @(posedge clk); #1;
    chk({tag, ".valid"}, {31'd0, bus.out_valid_o}, 32'd1);
    chk({tag, ".result"}, bus.result_o, er);
    chk({tag, ".fflags"}, {27'd0, bus.fflags_o}, {27'd0, ef});
  endtask

  logic [31:0] bp_in  [4];
  logic [1:0]  bp_rs  [4];
  logic [31:0] bp_exp [4];
  logic [4:0]  bp_fl  [4];
  int sent;
  int got;

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    flush  = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    drive(32'd0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000);

    bp_in[0] = 32'h3F80_0000; bp_rs[0] = 2'b11; bp_exp[0] = 32'h3F80_0001; bp_fl[0] = 5'h01;
    bp_in[1] = 32'h4000_0000; bp_rs[1] = 2'b00; bp_exp[1] = 32'h4000_0000; bp_fl[1] = 5'h00;
    bp_in[2] = 32'h3F80_0001; bp_rs[2] = 2'b10; bp_exp[2] = 32'h3F80_0002; bp_fl[2] = 5'h01;
    bp_in[3] = 32'hC040_0000; bp_rs[3] = 2'b11; bp_exp[3] = 32'hC040_0001; bp_fl[3] = 5'h01;

    repeat (3) @(posedge clk);
    #1;
    chk("reset.out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    chk("reset.result", bus.result_o, 32'd0);
    chk("reset.fflags", {27'd0, bus.fflags_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset.in_ready", {31'd0, bus.in_ready_o}, 32'd1);

    run_one("rne_up",     32'h3F80_0000, 2'b11, 1, 0, 2'b00, 3'b000, 32'h3F80_0001, 5'h01);
    run_one("rne_tie_ev", 32'h3F80_0000, 2'b10, 1, 0, 2'b00, 3'b000, 32'h3F80_0000, 5'h01);
    run_one("rne_tie_od", 32'h3F80_0001, 2'b10, 1, 0, 2'b00, 3'b000, 32'h3F80_0002, 5'h01);
    run_one("rne_ovf",    32'h7F7F_FFFF, 2'b10, 1, 0, 2'b00, 3'b000, 32'h7F80_0000, 5'h05);
    run_one("rtz_max",    32'h7F7F_FFFF, 2'b10, 1, 0, 2'b00, 3'b001, 32'h7F7F_FFFF, 5'h01);
    run_one("rdn_novf",   32'hFF7F_FFFF, 2'b10, 1, 0, 2'b00, 3'b010, 32'hFF80_0000, 5'h05);
    run_one("pass_nan",   32'h7FC0_0000, 2'b00, 0, 1, 2'b00, 3'b000, 32'h7FC0_0000, 5'h10);
    run_one("und_rup",    32'h0000_0000, 2'b00, 1, 0, 2'b10, 3'b011, 32'h0000_0001, 5'h03);
    run_one("und_rne_n",  32'h8000_0000, 2'b00, 1, 0, 2'b10, 3'b000, 32'h8000_0000, 5'h03);
    run_one("ovf_rup_n",  32'hC000_0000, 2'b00, 1, 0, 2'b01, 3'b011, 32'hFF7F_FFFF, 5'h05);
    run_one("ovf_rdn_p",  32'h4000_0000, 2'b00, 1, 0, 2'b01, 3'b010, 32'h7F7F_FFFF, 5'h05);
    run_one("ovf_e255",   32'h7F80_0000, 2'b00, 1, 0, 2'b00, 3'b001, 32'h7F7F_FFFF, 5'h05);
    run_one("rmm_tie",    32'h3F80_0000, 2'b10, 1, 0, 2'b00, 3'b100, 32'h3F80_0001, 5'h01);
    run_one("rup_sub_uf", 32'h0000_0001, 2'b01, 1, 0, 2'b00, 3'b011, 32'h0000_0002, 5'h03);
    run_one("rup_neg",    32'hBF80_0000, 2'b01, 1, 0, 2'b00, 3'b011, 32'hBF80_0000, 5'h01);
    run_one("rm_inval",   32'h3F80_0001, 2'b10, 1, 0, 2'b00, 3'b111, 32'h3F80_0002, 5'h01);
    run_one("exact",      32'h4049_0FDB, 2'b00, 1, 0, 2'b00, 3'b000, 32'h4049_0FDB, 5'h00);

    // Backpressure: four back-to-back inputs, consumer stalled for three cycles.
    @(posedge clk); #1;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      bus.out_ready_i = (c >= 5);
      bus.in_valid_i  = (sent < 4);
      if (sent < 4) drive(bp_in[sent], bp_rs[sent], 1, 0, 2'b00, 3'b000);
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        chk("bp.in_ready_low", {31'd0, bus.in_ready_o}, 32'd0);
        chk("bp.hold_valid", {31'd0, bus.out_valid_o}, 32'd1);
        chk("bp.hold_result", bus.result_o, bp_exp[0]);
        chk("bp.hold_fflags", {27'd0, bus.fflags_o}, {27'd0, bp_fl[0]});
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        chk("bp.order_result", bus.result_o, bp_exp[got]);
        chk("bp.order_fflags", {27'd0, bus.fflags_o}, {27'd0, bp_fl[got]});
        got++;
      end
      if (bus.in_valid_i && bus.in_ready_o) sent++;
      @(posedge clk); #1;
    end
    bus.in_valid_i = 1'b0;
    chk("bp.sent_count", sent, 32'd4);
    chk("bp.got_count", got, 32'd4);
    @(posedge clk); #1;
    chk("bp.no_dup", {31'd0, bus.out_valid_o}, 32'd0);

    // Asynchronous reset with an entry sitting at the output.
    bus.out_ready_i = 1'b0;
    drive(32'h3F80_0000, 2'b11, 1, 0, 2'b00, 3'b000);
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("rst.pre_valid", {31'd0, bus.out_valid_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    chk("rst.result", bus.result_o, 32'd0);
    chk("rst.fflags", {27'd0, bus.fflags_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", {31'd0, bus.in_ready_o}, 32'd1);
    chk("rst.idle", {31'd0, bus.out_valid_o}, 32'd0);

    // Flush with one entry in S1 and a second being accepted.
    drive(32'h4000_0000, 2'b00, 1, 0, 2'b00, 3'b000);
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    drive(32'h3F80_0000, 2'b11, 1, 0, 2'b00, 3'b000);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("flush.no_out", {31'd0, bus.out_valid_o}, 32'd0);
      @(posedge clk); #1;
    end

    run_one("post_flush", 32'h3F80_0000, 2'b11, 1, 0, 2'b00, 3'b000, 32'h3F80_0001, 5'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_round_pipe.md
# fp_round_pipe

Two-stage pipelined FP32 rounding unit that consumes the unrounded `uround_res_t` produced by the FP64→FP32 conversion stage (and any other FP32 producer using the same struct) and emits the final IEEE-754 binary32 result plus accrued exception flags. It sits directly downstream of the converter. It adds valid/ready flow control, so the converter output can be registered and back-pressured by the writeback path.

## Interface
- No parameters; format fixed to FP32 via `Structs #(.FP_FORMAT(FP32))`.
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous kill of all in-flight entries.
- in_valid_i  in  1  input entry valid.
- in_ready_o  out  1  unit can accept an entry this cycle.
- urnd_i  in  uround_res_t  fields: u_result {sign,exp[7:0],mant[22:0]}, rs[1:0] (round, sticky), round_en, invalid, exp_cout[1:0].
- rm_i  in  3  rounding mode: RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100; other codes behave as RNE.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- result_o  out  32  rounded binary32.
- fflags_o  out  5  {NV,DZ,OF,UF,NX}; DZ always 0.

## Operation
- Stage 1 (S1) registers urnd_i and rm_i. It classifies each entry as PASS, UNDER, OVER or NORM and computes inc.
- PASS (round_en=0): result = u_result unchanged, fflags = {invalid,4'b0}.
- UNDER (round_en=1, exp_cout[1]=1): result = ±0. Exception: RUP with sign=0, and RDN with sign=1, give ±0x00000001. fflags = UF|NX.
- OVER (round_en=1, exp_cout[1]=0, exp_cout[0]=1 or exp=255): result = ±inf for RNE/RMM. RTZ gives ±0x7F7FFFFF. RUP gives +inf when positive, else -max finite. RDN gives -inf when negative, else +max finite. fflags = OF|NX.
- NORM: r=rs[1], s=rs[0], l=mant[0]. inc is decided per mode:
  - RNE: r&(s|l)
  - RTZ: 0
  - RDN: sign&(r|s)
  - RUP: ~sign&(r|s)
  - RMM: r
- Stage 2 (S2) computes {exp,mant}+inc as a 31-bit add; a mantissa carry increments exp.
  - If the sum exp reaches 255, the entry is handled as OVER.
  - NX = r|s.
  - UF = NX & (exp==0 before rounding).
  - NV = invalid.
- Exactly one class applies per entry, with priority PASS > UNDER > OVER > NORM.

## Timing
- Latency: 2 cycles from in_valid_i&in_ready_o to out_valid_o.
- Throughput: 1 entry per cycle, no bubbles when out_ready_i=1.
- Handshake:
  - Transfer occurs when valid&ready.
  - in_ready_o = ~s1_valid | ~s2_valid | out_ready_i, i.e. the pipeline advances as a whole.
  - in_ready_o has no combinational path from in_valid_i.
- Output hold: while out_valid_o=1 and out_ready_i=0, result_o and fflags_o are held stable. Both stages hold, and at most 2 entries are stored.
- Ordering: entries leave in acceptance order.
- flush_i: on the next edge, both stage valids clear and the input accepted in that same cycle is dropped. flush_i has priority over every other event.
- Reset (asynchronous, including mid-operation):
  - out_valid_o=0, result_o=0, fflags_o=0.
  - Stage valids clear.
  - in_ready_o=1 from the first cycle after reset deassertion.
- Simultaneous events: when out_ready_i=1 and S2 is full, a new input is accepted in the same cycle.

## Structure
- fp_pkg: add `roundmode_e` (3-bit enum of the codes above) and `fflags_t` packed struct {NV,DZ,OF,UF,NX}. Reuse the existing `uround_res_t` and `fp_encoding_t`.
- Sub-module `fp_round_decide`: combinational; inputs sign, l, r, s, rm; output inc. Shared with future rounding users.
- Pipeline control (valid regs, advance enable) stays in the top module.

## Test plan
- u_result=0x3F800000, rs=11, RNE, round_en=1 → result 0x3F800001, fflags NX (0x01), 2 cycles after accept.
- Tie case, u_result=0x3F800000, rs=10, RNE → 0x3F800000 NX. With u_result=0x3F800001 and the same inputs → 0x3F800002 NX.
- u_result=0x7F7FFFFF, rs=10:
  - RNE → 0x7F800000, OF|NX (0x05).
  - RTZ → 0x7F7FFFFF, NX.
  - RDN with sign=1 → 0xFF800000, OF|NX.
- round_en=0, invalid=1, u_result=0x7FC00000 → 0x7FC00000, NV (0x10). exp_cout[1]=1, sign=0, RUP → 0x00000001, UF|NX.
- Backpressure:
  - Stimulus: 4 back-to-back inputs, out_ready_i=0 for 3 cycles.
  - Expect in_ready_o to fall once 2 entries are held, and outputs to stay stable.
  - Then set out_ready_i=1: all 4 results emerge in order, with none lost or duplicated.
- Kill paths:
  - Assert rst_ni=0 mid-stream → out_valid_o=0 immediately.
  - Assert flush_i with 2 entries in flight → no output is produced for them.
